wb_arbiter: RTL and testbench

Writeback arbiter and load scoreboard sitting between the execute/memory stages and the write port of the 32×64-bit register file. It merges single-cycle ALU results and variable-latency load results into the single register-file write port, buffering loads that lose arbitration. It also tracks destination registers of outstanding loads so decode can stall on read-after-write hazards.

---
 rtl/wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges single-cycle ALU results and variable-latency load
// results onto the single register-file write port. Loads that lose
// arbitration wait in a small in-order buffer. A busy mask tracks the
// destinations of outstanding loads so decode can stall on RAW hazards.
//
// Load-result handshake: a result transfers on a rising edge where
// ld_valid_in && ld_ready_out. ld_ready_out is derived only from the
// registered buffer count, so a full buffer never accepts, even when it
// drains in the same cycle.
module wb_arbiter #(
    parameter int XLEN     = 64,
    parameter int LQ_DEPTH = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            alu_valid_in,
    input  logic [4:0]                      alu_rd_in,
    input  logic [XLEN-1:0]                 alu_data_in,
    input  logic                            ld_issue_in,
    input  logic [4:0]                      ld_issue_rd_in,
    input  logic                            ld_valid_in,
    output logic                            ld_ready_out,
    input  logic [4:0]                      ld_rd_in,
    input  logic [XLEN-1:0]                 ld_data_in,
    input  logic [4:0]                      rs1_in,
    input  logic [4:0]                      rs2_in,
    output logic                            rs1_busy_out,
    output logic                            rs2_busy_out,
    output logic                            write_en_out,
    output logic [4:0]                      write_reg_num_out,
    output logic [XLEN-1:0]                 reg_write_out,
    output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count_out
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LQ_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LQ_DEPTH - 1);

    logic [4:0]      q_rd   [LQ_DEPTH];
    logic [XLEN-1:0] q_data [LQ_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [31:0] busy;
    logic [31:0] busy_next;
    // Marks that the write currently on the port came from the load path,
    // so its destination's busy bit retires with the register-file write.
    logic        from_load;

    logic alu_win;
    logic ld_accept;
    logic ld_keep;
    logic drain;
    logic bypass;
    logic enq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Arbitration: non-x0 ALU first, then buffer head, then same-cycle load.
    always_comb begin
        ld_ready_out = !rst_in && (count < FULL_CNT);
        alu_win      = alu_valid_in && (alu_rd_in != 5'd0);
        ld_accept    = ld_valid_in && ld_ready_out;
        ld_keep      = ld_accept && (ld_rd_in != 5'd0);
        drain        = !alu_win && (count != '0);
        bypass       = !alu_win && (count == '0) && ld_keep;
        enq          = ld_keep && !bypass;
    end

    // Registered write port; address and data hold when nothing is written.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            write_en_out      <= 1'b0;
            write_reg_num_out <= 5'd0;
            reg_write_out     <= '0;
            from_load         <= 1'b0;
        end else if (alu_win) begin
            write_en_out      <= 1'b1;
            write_reg_num_out <= alu_rd_in;
            reg_write_out     <= alu_data_in;
            from_load         <= 1'b0;
        end else if (drain) begin
            write_en_out      <= 1'b1;
            write_reg_num_out <= q_rd[head];
            reg_write_out     <= q_data[head];
            from_load         <= 1'b1;
        end else if (bypass) begin
            write_en_out      <= 1'b1;
            write_reg_num_out <= ld_rd_in;
            reg_write_out     <= ld_data_in;
            from_load         <= 1'b1;
        end else begin
            write_en_out      <= 1'b0;
            from_load         <= 1'b0;
        end
    end

    // Buffer storage; contents are meaningless outside head..tail so no reset.
    always_ff @(posedge clk_in) begin
        if (enq) begin
            q_rd[tail]   <= ld_rd_in;
            q_data[tail] <= ld_data_in;
        end
    end

    // Buffer pointers and occupancy; reset discards in-flight entries.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= ptr_inc(tail);
            if (drain) head <= ptr_inc(head);
            if (enq && !drain)      count <= count + 1'b1;
            else if (!enq && drain) count <= count - 1'b1;
        end
    end

    // Scoreboard next state: retire on load write-back, set on issue (set wins).
    always_comb begin
        busy_next = busy;
        if (write_en_out && from_load) busy_next[write_reg_num_out] = 1'b0;
        if (ld_issue_in)               busy_next[ld_issue_rd_in]    = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_in) begin
        if (rst_in) busy <= '0;
        else        busy <= busy_next;
    end

    assign rs1_busy_out = busy[rs1_in];
    assign rs2_busy_out = busy[rs2_in];
    assign lq_count_out = count;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_wb_arbiter;
  localparam int XLEN = 64;
  localparam int LQ_DEPTH = 2;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic clk = 1'b0;
  logic rst_in;
  logic alu_valid_in;
  logic [4:0] alu_rd_in;
  logic [XLEN-1:0] alu_data_in;
  logic ld_issue_in;
  logic [4:0] ld_issue_rd_in;
  logic ld_valid_in;
  logic ld_ready_out;
  logic [4:0] ld_rd_in;
  logic [XLEN-1:0] ld_data_in;
  logic [4:0] rs1_in, rs2_in;
  logic rs1_busy_out, rs2_busy_out;
  logic write_en_out;
  logic [4:0] write_reg_num_out;
  logic [XLEN-1:0] reg_write_out;
  logic [CNT_W-1:0] lq_count_out;

  wb_arbiter #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .alu_valid_in(alu_valid_in), .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
    .ld_issue_in(ld_issue_in), .ld_issue_rd_in(ld_issue_rd_in),
    .ld_valid_in(ld_valid_in), .ld_ready_out(ld_ready_out),
    .ld_rd_in(ld_rd_in), .ld_data_in(ld_data_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .rs1_busy_out(rs1_busy_out), .rs2_busy_out(rs2_busy_out),
    .write_en_out(write_en_out), .write_reg_num_out(write_reg_num_out),
    .reg_write_out(reg_write_out), .lq_count_out(lq_count_out)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // model state: buffer as a queue of {rd, data}, busy as a bit per register
  logic [XLEN+4:0] exp_q[$];
  bit [31:0] m_busy;
  bit m_we;
  logic [4:0] m_wa;
  logic [XLEN-1:0] m_wd;
  bit m_from_ld;
  bit m_known = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !rst_in && (exp_q.size() < LQ_DEPTH);
  endfunction

  // one clock edge of the specified behaviour
  task automatic model_step();
    bit accept;
    logic [XLEN+4:0] e;
    if (rst_in) begin
      exp_q.delete();
      m_busy = '0; m_we = 0; m_wa = '0; m_wd = '0; m_from_ld = 0;
      m_known = 1;
      return;
    end
    accept = ld_valid_in && m_ready();
    if (m_we && m_from_ld) m_busy[m_wa] = 1'b0;
    if (ld_issue_in && ld_issue_rd_in != 0) m_busy[ld_issue_rd_in] = 1'b1;
    if (alu_valid_in && alu_rd_in != 0) begin
      m_we = 1; m_wa = alu_rd_in; m_wd = alu_data_in; m_from_ld = 0;
      if (accept && ld_rd_in != 0) exp_q.push_back({ld_rd_in, ld_data_in});
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_we = 1; m_wa = e[XLEN+4:XLEN]; m_wd = e[XLEN-1:0]; m_from_ld = 1;
      if (accept && ld_rd_in != 0) exp_q.push_back({ld_rd_in, ld_data_in});
    end else if (accept && ld_rd_in != 0) begin
      m_we = 1; m_wa = ld_rd_in; m_wd = ld_data_in; m_from_ld = 1;
    end else begin
      m_we = 0; m_from_ld = 0;
    end
  endtask

  // compare current outputs to the model, then advance one cycle
  task automatic tick();
    #1;
    if (m_known) begin
      check("write_en", write_en_out, m_we);
      check("write_reg_num", write_reg_num_out, m_wa);
      check("reg_write", reg_write_out, m_wd);
      check("ld_ready", ld_ready_out, m_ready());
      check("lq_count", lq_count_out, exp_q.size());
      check("rs1_busy", rs1_busy_out, m_busy[rs1_in]);
      check("rs2_busy", rs2_busy_out, m_busy[rs2_in]);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // driver helpers
  task automatic idle();
    rst_in = 0; alu_valid_in = 0; alu_rd_in = 0; alu_data_in = 0;
    ld_issue_in = 0; ld_issue_rd_in = 0; ld_valid_in = 0; ld_rd_in = 0;
    ld_data_in = 0; rs1_in = 0; rs2_in = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    alu_valid_in = 1; alu_rd_in = rd; alu_data_in = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [XLEN-1:0] d);
    ld_valid_in = 1; ld_rd_in = rd; ld_data_in = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue_in = 1; ld_issue_rd_in = rd;
  endtask

  initial begin
    idle();
    rst_in = 1;
    #1 check("ld_ready_in_reset", ld_ready_out, 0);
    tick();
    check("reset_we", write_en_out, 0);
    check("reset_count", lq_count_out, 0);
    check("reset_addr", write_reg_num_out, 0);
    check("reset_data", reg_write_out, 0);
    idle();
    #1 check("ld_ready_after_reset", ld_ready_out, 1);

    // ALU only
    alu(5, 64'h1234); tick();
    check("alu_we", write_en_out, 1);
    check("alu_addr", write_reg_num_out, 5);
    check("alu_data", reg_write_out, 64'h1234);
    idle(); alu(0, 64'h55); tick();
    check("alu_x0_we", write_en_out, 0);
    check("alu_x0_hold_addr", write_reg_num_out, 5);

    // load bypass with scoreboard
    idle(); issue(7); tick();
    idle(); rs1_in = 7;
    #1 check("busy7_set", rs1_busy_out, 1);
    ld(7, 64'hDEAD); tick();
    check("bypass_we", write_en_out, 1);
    check("bypass_addr", write_reg_num_out, 7);
    check("bypass_data", reg_write_out, 64'hDEAD);
    idle(); rs2_in = 7;
    #1 check("busy7_during_write", rs2_busy_out, 1);
    tick();
    idle(); rs1_in = 7;
    #1 check("busy7_cleared", rs1_busy_out, 0);

    // collision: ALU rd=3 for four cycles, loads 8 and 9 buffered
    idle(); alu(3, 64'h30); ld(8, 64'h80); tick();
    idle(); alu(3, 64'h31); ld(9, 64'h90); tick();
    check("full_count", lq_count_out, 2);
    check("full_ready", ld_ready_out, 0);
    idle(); alu(3, 64'h32); tick();
    idle(); alu(3, 64'h33); tick();
    check("still_full", lq_count_out, 2);
    check("alu_wins_addr", write_reg_num_out, 3);
    idle(); tick();
    check("drain1_addr", write_reg_num_out, 8);
    check("drain1_data", reg_write_out, 64'h80);
    check("drain1_ready", ld_ready_out, 1);
    tick();
    check("drain2_addr", write_reg_num_out, 9);
    check("drain2_data", reg_write_out, 64'h90);
    check("drain2_count", lq_count_out, 0);

    // set/clear race on rd=4
    idle(); issue(4); tick();
    idle(); ld(4, 64'h44); tick();
    check("race_write_addr", write_reg_num_out, 4);
    idle(); issue(4); tick();
    idle(); rs1_in = 4;
    #1 check("race_set_wins", rs1_busy_out, 1);
    tick();

    // x0 handling
    idle(); alu(3, 64'h3); ld(6, 64'h66); tick();
    check("x0_buffered", lq_count_out, 1);
    idle(); alu(0, 64'hBAD); tick();
    check("x0_alu_drain_we", write_en_out, 1);
    check("x0_alu_drain_addr", write_reg_num_out, 6);
    check("x0_alu_drain_data", reg_write_out, 64'h66);
    idle(); ld(0, 64'hBAD); tick();
    check("ld_x0_no_write", write_en_out, 0);
    check("ld_x0_count", lq_count_out, 0);

    // reset mid-operation
    idle(); issue(10); tick();
    idle(); alu(3, 64'h1); ld(11, 64'hB); tick();
    idle(); alu(3, 64'h2); ld(12, 64'hC); tick();
    check("pre_reset_count", lq_count_out, 2);
    idle(); rst_in = 1;
    #1 check("ready_low_in_reset", ld_ready_out, 0);
    tick();
    check("mid_reset_count", lq_count_out, 0);
    check("mid_reset_we", write_en_out, 0);
    for (int i = 0; i < 5; i++) begin
      idle(); rs1_in = 10; rs2_in = 11;
      #1 check("post_reset_busy10", rs1_busy_out, 0);
      tick();
      check("no_stale_write", write_en_out, 0);
    end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      idle();
      rst_in = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 45) alu($urandom_range(0, 7), {$urandom, $urandom});
      if ($urandom_range(0, 99) < 30) issue($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 50) ld($urandom_range(0, 7), {$urandom, $urandom});
      rs1_in = $urandom_range(0, 7);
      rs2_in = $urandom_range(0, 31);
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
